// File: rtl/register_file_if.sv
// register_file_if: bus between decode/writeback and the register file
// (two combinational read ports, one clocked write port).
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  we3_i;
    logic [ADDR_WIDTH-1:0] a1_i;
    logic [ADDR_WIDTH-1:0] a2_i;
    logic [ADDR_WIDTH-1:0] a3_i;
    logic [DATA_WIDTH-1:0] wd3_i;
    logic [DATA_WIDTH-1:0] rd1_o;
    logic [DATA_WIDTH-1:0] rd2_o;
    modport master (output we3_i, a1_i, a2_i, a3_i, wd3_i, input rd1_o, rd2_o);
    modport slave  (input we3_i, a1_i, a2_i, a3_i, wd3_i, output rd1_o, rd2_o);
endinterface

// File: rtl/register_file.sv
// register_file: RV32I integer register file, x0 hardwired to zero.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic            clk_i,
    input logic            reset_i,
    register_file_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  byp1;
    logic                  byp2;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (rf.we3_i && rf.a3_i != '0) begin
            regs[rf.a3_i] <= rf.wd3_i;
        end
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    // a3_i != 0 already excludes x0 from forwarding
    assign byp1 = rf.we3_i && !reset_i && rf.a3_i != '0 && rf.a1_i == rf.a3_i;
    assign byp2 = rf.we3_i && !reset_i && rf.a3_i != '0 && rf.a2_i == rf.a3_i;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif
    always_comb begin
        rf.rd1_o = (rf.a1_i == '0) ? '0 : byp1 ? rf.wd3_i : regs[rf.a1_i];
        rf.rd2_o = (rf.a2_i == '0) ? '0 : byp2 ? rf.wd3_i : regs[rf.a2_i];
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file against a shadow model.
module tb_register_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    logic [31:0] e;
`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.clk_i(clk), .reset_i(rst), .rf(bus));

    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] a3, input logic [31:0] wd);
        bus.we3_i = we;
        bus.a1_i  = a1;
        bus.a2_i  = a2;
        bus.a3_i  = a3;
        bus.wd3_i = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst && bus.we3_i && bus.a3_i != 0) model[bus.a3_i] = bus.wd3_i;
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 32'd12345);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        tick();
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL reset_rd1 got=%h exp=%h", bus.rd1_o, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd2_o !== e) begin errors++; $display("FAIL reset_rd2 got=%h exp=%h", bus.rd2_o, e); end
        drive(1'b1, 5'd0, 5'd4, 5'd5, 32'd9876);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        tick();
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL reset2_rd1 got=%h exp=%h", bus.rd1_o, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd2_o !== e) begin errors++; $display("FAIL reset2_rd2 got=%h exp=%h", bus.rd2_o, e); end
        drive(1'b0, 5'd3, 5'd5, 5'd0, 32'd0);
        rst = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL reset_reg3_held got=%h exp=%h", bus.rd1_o, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd2_o !== e) begin errors++; $display("FAIL reset_reg5_held got=%h exp=%h", bus.rd2_o, e); end
    endtask

    task automatic test_write_read();
        tick();
        drive(1'b1, 5'd3, 5'd3, 5'd3, 32'd12345);
        exp_q.push_back(BYPASS ? 32'd12345 : 32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL pre_edge_rd1 got=%h exp=%h", bus.rd1_o, e); end
        exp_q.push_back(32'd12345);
        exp_q.push_back(32'd12345);
        tick();
        bus.we3_i = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL post_edge_rd1 got=%h exp=%h", bus.rd1_o, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd2_o !== e) begin errors++; $display("FAIL post_edge_rd2 got=%h exp=%h", bus.rd2_o, e); end
    endtask

    task automatic test_zero();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        tick();
        bus.we3_i = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL x0_rd1 got=%h exp=%h", bus.rd1_o, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd2_o !== e) begin errors++; $display("FAIL x0_rd2 got=%h exp=%h", bus.rd2_o, e); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 32'd9876);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd31, 32'hFFFFFFFF);
        tick();
        drive(1'b0, 5'd5, 5'd31, 5'd0, 32'd0);
        exp_q.push_back(32'd9876);
        exp_q.push_back(32'hFFFFFFFF);
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL b2b_reg5 got=%h exp=%h", bus.rd1_o, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd2_o !== e) begin errors++; $display("FAIL b2b_reg31 got=%h exp=%h", bus.rd2_o, e); end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        rst = 1'b1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL async_rst_rd1 got=%h exp=%h", bus.rd1_o, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd2_o !== e) begin errors++; $display("FAIL async_rst_rd2 got=%h exp=%h", bus.rd2_o, e); end
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        tick();
        drive(1'b1, 5'd7, 5'd7, 5'd7, 32'd42);
        exp_q.push_back(BYPASS ? 32'd42 : model[7]);
        exp_q.push_back(BYPASS ? 32'd42 : model[7]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL bypass_rd1 got=%h exp=%h", bus.rd1_o, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd2_o !== e) begin errors++; $display("FAIL bypass_rd2 got=%h exp=%h", bus.rd2_o, e); end
        tick();
        drive(1'b1, 5'd0, 5'd7, 5'd0, 32'd99);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd42);
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.rd1_o !== e) begin errors++; $display("FAIL bypass_x0 got=%h exp=%h", bus.rd1_o, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd2_o !== e) begin errors++; $display("FAIL bypass_reg7 got=%h exp=%h", bus.rd2_o, e); end
        tick();
        bus.we3_i = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int n = 0; n < 60; n++) begin
            a = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), a, ~a, a, $urandom);
            tick();
        end
        bus.we3_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.a1_i = 5'(i);
            bus.a2_i = 5'(31 - i);
            exp_q.push_back(model[i]);
            exp_q.push_back(model[31 - i]);
            #1;
            e = exp_q.pop_front(); checks++;
            if (bus.rd1_o !== e) begin errors++; $display("FAIL rand_rd1[%0d] got=%h exp=%h", i, bus.rd1_o, e); end
            e = exp_q.pop_front(); checks++;
            if (bus.rd2_o !== e) begin errors++; $display("FAIL rand_rd2[%0d] got=%h exp=%h", 31 - i, bus.rd2_o, e); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        test_reset();
        test_write_read();
        test_zero();
        test_back_to_back();
        test_async_reset();
        test_bypass();
        test_random();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
